// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// forwarding select codes and the EX-stage shadow record.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LSTALL = 2'b01,
    ST_MWAIT  = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Register 15 is the PC and never takes a forwarded value
  localparam logic [3:0] PC_REG = 4'd15;

  // Shadow of the control fields carried alongside the instruction in EX
  typedef struct packed {
    logic [3:0] rd;
    logic       rf_en;
    logic       load;
    logic       mem_en;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{rd: 4'd0, rf_en: 1'b0, load: 1'b0, mem_en: 1'b0};

  // True when an ID operand that is actually read names the given register
  function automatic logic src_hit(input logic use_bit, input logic [3:0] src,
                                   input logic [3:0] rd);
    return use_bit && (src == rd);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding source selection for one ID operand: youngest producer wins.
module fwd_select
  import hazard_pkg::*;
(
  input  logic       i_en,
  input  logic [3:0] i_src,
  input  logic [3:0] i_ex_rd,
  input  logic       i_ex_wr,
  input  logic [3:0] i_mem_rd,
  input  logic       i_mem_wr,
  input  logic [3:0] i_wb_rd,
  input  logic       i_wb_wr,
  output logic [1:0] o_sel
);

  // Priority EX > MEM > WB; the PC and the reset condition always read the RF
  always_comb begin
    o_sel = FWD_RF;
    if (!i_en || (i_src == PC_REG)) begin
      o_sel = FWD_RF;
    end else if (i_ex_wr && (i_ex_rd == i_src)) begin
      o_sel = FWD_EX;
    end else if (i_mem_wr && (i_mem_rd == i_src)) begin
      o_sel = FWD_MEM;
    end else if (i_wb_wr && (i_wb_rd == i_src)) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, data-memory wait,
// branch flush and operand forwarding, driven from a shadow of EX/MEM/WB.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       R,
  input  logic [3:0] ID_Rn,
  input  logic [3:0] ID_Rm,
  input  logic [3:0] ID_Rd,
  input  logic       ID_use_Rn,
  input  logic       ID_use_Rm,
  input  logic       ID_use_Rd,
  input  logic       ID_RF_enable,
  input  logic       ID_load_instr,
  input  logic       ID_mem_en,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       PC_LE,
  output logic       IFID_LE,
  output logic       pipe_LE,
  output logic       SS,
  output logic       IFID_flush,
  output logic [1:0] fwd_A,
  output logic [1:0] fwd_B,
  output logic [1:0] fwd_C,
  output logic [1:0] state,
  output logic [7:0] stall_count
);

  // EX keeps the full record; past EX only the fields still consulted travel on
  shadow_t    r_ex;
  logic [3:0] r_mem_rd;
  logic       r_mem_wr;
  logic       r_mem_en;
  logic [3:0] r_wb_rd;
  logic       r_wb_wr;
  state_t     r_state;
  logic [7:0] r_stall_count;

  logic       w_mem_wait;
  logic       w_load_use;
  shadow_t    w_id_shadow;

  assign w_id_shadow = '{rd: ID_Rd, rf_en: ID_RF_enable, load: ID_load_instr, mem_en: ID_mem_en};

  // MEM wait: the access in MEM has not completed this cycle
  assign w_mem_wait = r_mem_en && !mem_ready;

  // Load-use: the load in EX produces a register that ID reads right now
  assign w_load_use = r_ex.load && r_ex.rf_en &&
                      (src_hit(ID_use_Rn, ID_Rn, r_ex.rd) ||
                       src_hit(ID_use_Rm, ID_Rm, r_ex.rd) ||
                       src_hit(ID_use_Rd, ID_Rd, r_ex.rd));

  // Pipeline control: reset, then MEM wait over load-use over branch flush
  always_comb begin
    PC_LE      = 1'b0;
    IFID_LE    = 1'b0;
    pipe_LE    = 1'b0;
    SS         = 1'b1;
    IFID_flush = 1'b0;
    if (!R) begin
      PC_LE      = 1'b0;
      IFID_LE    = 1'b0;
      pipe_LE    = 1'b0;
      SS         = 1'b1;
      IFID_flush = 1'b0;
    end else if (w_mem_wait) begin
      PC_LE      = 1'b0;
      IFID_LE    = 1'b0;
      pipe_LE    = 1'b0;
      SS         = 1'b0;
      IFID_flush = 1'b0;
    end else if (w_load_use) begin
      PC_LE      = 1'b0;
      IFID_LE    = 1'b0;
      pipe_LE    = 1'b1;
      SS         = 1'b1;
      IFID_flush = 1'b0;
    end else begin
      PC_LE      = 1'b1;
      IFID_LE    = 1'b1;
      pipe_LE    = 1'b1;
      SS         = 1'b0;
      IFID_flush = branch_taken;
    end
  end

  // Shadow pipeline and FSM: hold on MEM wait, bubble EX on load-use, else shift
  always_ff @(posedge clk) begin
    if (!R) begin
      r_ex     <= SHADOW_BUBBLE;
      r_mem_rd <= 4'd0;
      r_mem_wr <= 1'b0;
      r_mem_en <= 1'b0;
      r_wb_rd  <= 4'd0;
      r_wb_wr  <= 1'b0;
      r_state  <= ST_RUN;
    end else if (w_mem_wait) begin
      r_ex     <= r_ex;
      r_mem_rd <= r_mem_rd;
      r_mem_wr <= r_mem_wr;
      r_mem_en <= r_mem_en;
      r_wb_rd  <= r_wb_rd;
      r_wb_wr  <= r_wb_wr;
      r_state  <= ST_MWAIT;
    end else if (w_load_use) begin
      r_ex     <= SHADOW_BUBBLE;
      r_mem_rd <= r_ex.rd;
      r_mem_wr <= r_ex.rf_en;
      r_mem_en <= r_ex.mem_en;
      r_wb_rd  <= r_mem_rd;
      r_wb_wr  <= r_mem_wr;
      r_state  <= ST_LSTALL;
    end else begin
      r_ex     <= w_id_shadow;
      r_mem_rd <= r_ex.rd;
      r_mem_wr <= r_ex.rf_en;
      r_mem_en <= r_ex.mem_en;
      r_wb_rd  <= r_mem_rd;
      r_wb_wr  <= r_mem_wr;
      r_state  <= ST_RUN;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (!R) begin
      r_stall_count <= 8'd0;
    end else if (!PC_LE && (r_stall_count != 8'd255)) begin
      r_stall_count <= r_stall_count + 8'd1;
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign state       = r_state;
  assign stall_count = r_stall_count;

  fwd_select u_fwd_a (
    .i_en     (R),
    .i_src    (ID_Rn),
    .i_ex_rd  (r_ex.rd),
    .i_ex_wr  (r_ex.rf_en),
    .i_mem_rd (r_mem_rd),
    .i_mem_wr (r_mem_wr),
    .i_wb_rd  (r_wb_rd),
    .i_wb_wr  (r_wb_wr),
    .o_sel    (fwd_A)
  );

  fwd_select u_fwd_b (
    .i_en     (R),
    .i_src    (ID_Rm),
    .i_ex_rd  (r_ex.rd),
    .i_ex_wr  (r_ex.rf_en),
    .i_mem_rd (r_mem_rd),
    .i_mem_wr (r_mem_wr),
    .i_wb_rd  (r_wb_rd),
    .i_wb_wr  (r_wb_wr),
    .o_sel    (fwd_B)
  );

  fwd_select u_fwd_c (
    .i_en     (R),
    .i_src    (ID_Rd),
    .i_ex_rd  (r_ex.rd),
    .i_ex_wr  (r_ex.rf_en),
    .i_mem_rd (r_mem_rd),
    .i_mem_wr (r_mem_wr),
    .i_wb_rd  (r_wb_rd),
    .i_wb_wr  (r_wb_wr),
    .o_sel    (fwd_C)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run compared against an instruction-list reference model.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       R;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       use_rn, use_rm, use_rd;
  logic       rf_en, ld, men, br, rdy;
  logic       PC_LE, IFID_LE, pipe_LE, SS, IFID_flush;
  logic [1:0] fwd_A, fwd_B, fwd_C, state;
  logic [7:0] stall_count;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .R(R),
    .ID_Rn(id_rn), .ID_Rm(id_rm), .ID_Rd(id_rd),
    .ID_use_Rn(use_rn), .ID_use_Rm(use_rm), .ID_use_Rd(use_rd),
    .ID_RF_enable(rf_en), .ID_load_instr(ld), .ID_mem_en(men),
    .branch_taken(br), .mem_ready(rdy),
    .PC_LE(PC_LE), .IFID_LE(IFID_LE), .pipe_LE(pipe_LE), .SS(SS),
    .IFID_flush(IFID_flush), .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_C(fwd_C),
    .state(state), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB
  int m_rd[3];
  bit m_wr[3];
  bit m_ld[3];
  bit m_me[3];
  int m_state;   // 0 RUN, 1 LSTALL, 2 MWAIT
  int m_cnt;
  bit m_wait, m_lu;
  logic [4:0] e_ctl;     // {PC_LE, IFID_LE, pipe_LE, SS, IFID_flush}
  logic [5:0] e_fwd;     // {fwd_A, fwd_B, fwd_C}

  function automatic logic [1:0] model_fwd(input int src);
    if (!R || src == 15) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (m_wr[k] && m_rd[k] == src) return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic model_eval();
    bit reads;
    reads = (use_rn && int'(id_rn) == m_rd[0]) || (use_rm && int'(id_rm) == m_rd[0]) ||
            (use_rd && int'(id_rd) == m_rd[0]);
    m_wait = R && m_me[1] && !rdy;
    m_lu   = R && !m_wait && m_ld[0] && m_wr[0] && reads;
    if (!R)          e_ctl = 5'b00010;
    else if (m_wait) e_ctl = 5'b00000;
    else if (m_lu)   e_ctl = 5'b00110;
    else             e_ctl = {4'b1110, br};
    e_fwd = {model_fwd(int'(id_rn)), model_fwd(int'(id_rm)), model_fwd(int'(id_rd))};
  endtask

  task automatic model_commit();
    if (!R) begin
      for (int k = 0; k < 3; k++) begin m_rd[k] = 0; m_wr[k] = 0; m_ld[k] = 0; m_me[k] = 0; end
      m_state = 0; m_cnt = 0;
    end else begin
      if (e_ctl[4] == 1'b0 && m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_wait) begin
        m_state = 2;
      end else begin
        for (int k = 2; k > 0; k--) begin
          m_rd[k] = m_rd[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1]; m_me[k] = m_me[k-1];
        end
        if (m_lu) begin
          m_rd[0] = 0; m_wr[0] = 0; m_ld[0] = 0; m_me[0] = 0; m_state = 1;
        end else begin
          m_rd[0] = int'(id_rd); m_wr[0] = rf_en; m_ld[0] = ld; m_me[0] = men; m_state = 0;
        end
      end
    end
  endtask

  task automatic set_id(input logic [3:0] rn, rm, rd, input logic urn, urm, urd,
                        input logic wr, l, me, b, rd_y);
    id_rn = rn; id_rm = rm; id_rd = rd; use_rn = urn; use_rm = urm; use_rd = urd;
    rf_en = wr; ld = l; men = me; br = b; rdy = rd_y;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic nop_cycle();
    set_id(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    advance();
  endtask

  task automatic do_reset();
    R = 1'b0;
    nop_cycle();
    R = 1'b1;
  endtask

  task automatic test_reset();
    R = 1'b0;
    set_id(4'd1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    total++;
    if ({PC_LE, IFID_LE, pipe_LE, SS, IFID_flush} !== 5'b00010) begin
      bad++; $display("FAIL reset_ctl got=%b exp=00010", {PC_LE, IFID_LE, pipe_LE, SS, IFID_flush});
    end
    total++;
    if ({fwd_A, fwd_B, fwd_C} !== 6'd0) begin
      bad++; $display("FAIL reset_fwd got=%b exp=000000", {fwd_A, fwd_B, fwd_C});
    end
    advance();
    R = 1'b1;
    set_id(4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if (state !== 2'b00 || stall_count !== 8'd0) begin
      bad++; $display("FAIL reset_state got state=%b cnt=%0d exp state=00 cnt=0", state, stall_count);
    end
    total++;
    if ({PC_LE, IFID_LE, pipe_LE, SS, IFID_flush} !== 5'b11100) begin
      bad++; $display("FAIL reset_run got=%b exp=11100", {PC_LE, IFID_LE, pipe_LE, SS, IFID_flush});
    end
    advance();
  endtask

  task automatic test_ex_forward();
    do_reset();
    set_id(4'd2, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    settle(); advance();
    set_id(4'd1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if (fwd_A !== 2'b01 || fwd_B !== 2'b00) begin
      bad++; $display("FAIL ex_fwd got A=%b B=%b exp A=01 B=00", fwd_A, fwd_B);
    end
    total++;
    if (PC_LE !== 1'b1 || SS !== 1'b0) begin
      bad++; $display("FAIL ex_fwd_nostall got PC_LE=%b SS=%b exp 1 0", PC_LE, SS);
    end
    advance();
    // Same register now sits in MEM, then in WB
    set_id(4'd1, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if (fwd_A !== 2'b10 || fwd_B !== 2'b10) begin
      bad++; $display("FAIL mem_fwd got A=%b B=%b exp 10 10", fwd_A, fwd_B);
    end
    advance();
    settle();
    total++;
    if (fwd_A !== 2'b11) begin
      bad++; $display("FAIL wb_fwd got A=%b exp 11", fwd_A);
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle(); advance();
    set_id(4'd2, 4'd4, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if ({PC_LE, IFID_LE, pipe_LE, SS} !== 4'b0011) begin
      bad++; $display("FAIL lu_stall got=%b exp=0011", {PC_LE, IFID_LE, pipe_LE, SS});
    end
    advance();
    settle();
    total++;
    if (state !== 2'b01 || fwd_B !== 2'b10 || stall_count !== 8'd1) begin
      bad++; $display("FAIL lu_after got state=%b B=%b cnt=%0d exp 01 10 1", state, fwd_B, stall_count);
    end
    total++;
    if (PC_LE !== 1'b1) begin
      bad++; $display("FAIL lu_release got PC_LE=%b exp 1", PC_LE);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_id(4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle(); advance();
    nop_cycle();
    for (int i = 0; i < 3; i++) begin
      set_id(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      total++;
      if ({PC_LE, IFID_LE, pipe_LE, SS, IFID_flush} !== 5'b00000) begin
        bad++; $display("FAIL mwait_ctl i=%0d got=%b exp=00000", i, {PC_LE, IFID_LE, pipe_LE, SS, IFID_flush});
      end
      advance();
    end
    rdy = 1'b1;
    settle();
    total++;
    if (state !== 2'b10 || stall_count !== 8'd3 || PC_LE !== 1'b1) begin
      bad++; $display("FAIL mwait_end got state=%b cnt=%0d PC_LE=%b exp 10 3 1", state, stall_count, PC_LE);
    end
    total++;
    if (IFID_flush !== 1'b1) begin
      bad++; $display("FAIL mwait_branch got flush=%b exp 1", IFID_flush);
    end
    advance();
    settle();
    total++;
    if (state !== 2'b00) begin
      bad++; $display("FAIL mwait_run got state=%b exp 00", state);
    end
    advance();
  endtask

  task automatic test_load_use_branch();
    do_reset();
    set_id(4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle(); advance();
    set_id(4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    total++;
    if (PC_LE !== 1'b0 || IFID_flush !== 1'b0) begin
      bad++; $display("FAIL lub_stall got PC_LE=%b flush=%b exp 0 0", PC_LE, IFID_flush);
    end
    advance();
    settle();
    total++;
    if (PC_LE !== 1'b1 || IFID_flush !== 1'b1) begin
      bad++; $display("FAIL lub_flush got PC_LE=%b flush=%b exp 1 1", PC_LE, IFID_flush);
    end
    advance();
  endtask

  task automatic test_r15();
    do_reset();
    set_id(4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    settle(); advance();
    set_id(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if ({fwd_A, fwd_B, fwd_C} !== 6'd0) begin
      bad++; $display("FAIL r15 got=%b exp=000000", {fwd_A, fwd_B, fwd_C});
    end
    advance();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    set_id(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle(); advance();
    nop_cycle();
    rdy = 1'b0;
    settle(); advance();
    settle(); advance();
    total++;
    if (state !== 2'b10) begin
      bad++; $display("FAIL rw_pre got state=%b exp 10", state);
    end
    R = 1'b0;
    settle();
    total++;
    if ({PC_LE, IFID_LE, pipe_LE, SS} !== 4'b0001) begin
      bad++; $display("FAIL rw_hold got=%b exp=0001", {PC_LE, IFID_LE, pipe_LE, SS});
    end
    advance();
    R = 1'b1;
    set_id(4'd7, 4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    total++;
    if (state !== 2'b00 || stall_count !== 8'd0 || {fwd_A, fwd_B, fwd_C} !== 6'd0 || PC_LE !== 1'b1) begin
      bad++; $display("FAIL rw_after got state=%b cnt=%0d fwd=%b PC_LE=%b exp 00 0 000000 1",
                      state, stall_count, {fwd_A, fwd_B, fwd_C}, PC_LE);
    end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    set_id(4'd0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle(); advance();
    nop_cycle();
    rdy = 1'b0;
    for (int i = 0; i < 260; i++) begin
      settle(); advance();
    end
    settle();
    total++;
    if (stall_count !== 8'd255 || state !== 2'b10) begin
      bad++; $display("FAIL sat got cnt=%0d state=%b exp 255 10", stall_count, state);
    end
    rdy = 1'b1;
    settle(); advance();
  endtask

  task automatic test_random();
    logic [3:0] regs [6];
    regs[0] = 4'd0; regs[1] = 4'd1; regs[2] = 4'd2; regs[3] = 4'd3; regs[4] = 4'd4; regs[5] = 4'd15;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      R = ($urandom_range(0, 49) != 0);
      set_id(regs[$urandom_range(0, 5)], regs[$urandom_range(0, 5)], regs[$urandom_range(0, 5)],
             1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
      settle();
      total++;
      if ({PC_LE, IFID_LE, pipe_LE, SS, IFID_flush} !== e_ctl) begin
        bad++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", c, {PC_LE, IFID_LE, pipe_LE, SS, IFID_flush}, e_ctl);
      end
      total++;
      if ({fwd_A, fwd_B, fwd_C} !== e_fwd) begin
        bad++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", c, {fwd_A, fwd_B, fwd_C}, e_fwd);
      end
      total++;
      if (state !== 2'(m_state)) begin
        bad++; $display("FAIL rnd_state cyc=%0d got=%b exp=%0d", c, state, m_state);
      end
      total++;
      if (stall_count !== 8'(m_cnt)) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, stall_count, m_cnt);
      end
      advance();
    end
  endtask

  initial begin
    R = 1'b0;
    set_id(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin m_rd[k] = 0; m_wr[k] = 0; m_ld[k] = 0; m_me[k] = 0; end
    m_state = 0; m_cnt = 0;
    test_reset();
    test_ex_forward();
    test_load_use();
    test_mem_wait();
    test_load_use_branch();
    test_r15();
    test_reset_in_wait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
